aes128_encrypt_iter: RTL and testbench
======================================

// Module: aes128_encrypt_iter
// PURPOSE
//  Iterative AES-128 encryption core (FIPS-197 Cipher): one 128-bit block in, one ciphertext out.
//  Rounds run sequentially on a single round datapath with on-the-fly key expansion.
//  Forward counterpart of the decrypt round path. Exports the final round key (w[40..43])
//  so the decrypt side can seed its inverse key schedule.
// PARAMETERS
//  RPC  1  rounds per clock; legal 1 or 2 (unrolled copies). Any other value is an elaboration error.
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    plaintext/key valid
//  in_ready   out  1    core idle, can accept a block
//  plaintext  in   128  byte0 = [127:120]; column-major state per FIPS-197
//  key        in   128  cipher key, same byte order
//  out_valid  out  1    ciphertext valid
//  out_ready  in   1    downstream accepts ciphertext
//  ciphertext out  128  result, same byte order
//  last_key   out  128  round-10 key, valid while out_valid
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; ciphertext=0; last_key=0; round counter=0.
//  - FSM IDLE -> ROUND -> DONE -> IDLE.
//  - IDLE
//    - in_ready=1.
//    - On in_valid&in_ready at edge T: st<=plaintext^key (round 0 AddRoundKey), rk<=key, rnd<=1, go ROUND.
//  - ROUND (in_ready=0)
//    - Per edge, apply RPC rounds.
//    - Each round r: rk'=KeyExp(rk,Rcon[r]); st'=AddRoundKey(MixColumns(ShiftRows(SubBytes(st))),rk').
//    - Round 10 omits MixColumns.
//    - Rcon: 01,02,04,08,10,20,40,80,1b,36.
//    - KeyExp: w0'=w0^SubWord(RotWord(w3))^{Rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//    - rnd += RPC. When the edge completes round 10, go DONE.
//  - DONE: out_valid=1; ciphertext=st; last_key=rk.
//    - Both held stable while out_ready=0 (no change under backpressure).
//    - On out_valid&out_ready: go IDLE, out_valid<=0.
//    - in_ready rises the cycle after the handshake; no same-cycle re-accept.
//  - Latency: accept at edge T -> out_valid high in the cycle after edge T+10/RPC.
//    - 11 cycles for RPC=1; 6 cycles for RPC=2.
//  - Throughput: at best one block per 10/RPC+2 cycles.
//  - plaintext and key are sampled only at the accept edge; later changes are ignored.
//  - in_valid while busy is ignored; the source must hold it until in_ready.
//  - rst mid-ROUND or in DONE: immediate return to IDLE; block discarded; out_valid=0 next cycle.
//  - Arithmetic: all GF(2^8) with xtime reduction 0x1b; no carries; widths fixed at 128/32/8.
//  - ciphertext and last_key outputs are registered. SubBytes is a combinational forward S-box.
// TESTING
//  1. FIPS-197 App.B, RPC=1:
//     key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734
//     -> ct=3925841d02dc09fbdc118597196a0b32; last_key=d014f9a8c9ee2589e13f0cc8b6630ca6;
//        out_valid 11 cycles after accept.
//  2. FIPS-197 App.C.1, RPC=1 and RPC=2:
//     key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff
//     -> ct=69c4e0d86a7b0430d8cdb78070b4c55a; latency 11 / 6 cycles.
//  3. Backpressure: hold out_ready=0 for 20 cycles after out_valid
//     -> ciphertext and last_key constant, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
//  4. Busy input: pulse in_valid with other data mid-ROUND
//     -> ignored; vector 1 result unchanged.
//  5. Reset at cycle 5 of ROUND
//     -> out_valid stays 0, in_ready=1 after reset.
//     Then vector 2 -> correct ct, no residue from the aborted block.
//  6. Back-to-back: in_valid held high, 4 random blocks
//     -> ct matches a software AES model; spacing 12 cycles (RPC=1).

Source files
------------

// File: rtl/aes128_encrypt_iter.sv
// rtl/aes128_encrypt_iter.sv - iterative AES-128 encryption core with on-the-fly key expansion
// RPC rounds are evaluated per clock; the final round key is exported for the decrypt key schedule.
module aes128_encrypt_iter #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic [127:0] last_key
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [3:0] RPC_STEP = 4'(RPC);
  localparam logic [3:0] LAST_RND = 4'(11 - RPC);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255 - int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ {sbox(rk[23:16]), sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])}
         ^ {rc, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the state sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] enc_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] s;
    logic [127:0] m;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[127-8*(4*c+r) -: 8] = sbox(st[127-8*(4*((c+r)%4)+r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      m[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      m[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      m[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      m[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return (last ? s : m) ^ rk;
  endfunction

  state_t       r_state;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [3:0]   r_rnd;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [127:0] r_ciphertext;
  logic [127:0] r_last_key;

  logic [127:0] w_rk1;
  logic [127:0] w_st1;
  logic [127:0] w_rk_n;
  logic [127:0] w_st_n;

  assign w_rk1 = key_exp(r_rk, rcon(r_rnd));
  assign w_st1 = enc_round(r_st, w_rk1, r_rnd == 4'd10);

  generate
    if (RPC == 1) begin : g_rpc1
      assign w_rk_n = w_rk1;
      assign w_st_n = w_st1;
    end else if (RPC == 2) begin : g_rpc2
      // Rounds pair up as (1,2)..(9,10), so only the second copy ever sees round 10.
      assign w_rk_n = key_exp(w_rk1, rcon(r_rnd + 4'd1));
      assign w_st_n = enc_round(w_st1, w_rk_n, (r_rnd + 4'd1) == 4'd10);
    end else begin : g_bad_rpc
      $error("aes128_encrypt_iter: RPC must be 1 or 2");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_st         <= '0;
      r_rk         <= '0;
      r_rnd        <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_ciphertext <= '0;
      r_last_key   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_st       <= plaintext ^ key;
            r_rk       <= key;
            r_rnd      <= 4'd1;
            r_in_ready <= 1'b0;
            r_state    <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_st  <= w_st_n;
          r_rk  <= w_rk_n;
          r_rnd <= r_rnd + RPC_STEP;
          if (r_rnd == LAST_RND) begin
            r_ciphertext <= w_st_n;
            r_last_key   <= w_rk_n;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_rnd       <= '0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ciphertext;
  assign last_key   = r_last_key;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// tb/tb_aes128_encrypt_iter.sv - directed and random checks of aes128_encrypt_iter (RPC=1 and RPC=2)
// Reference: FIPS-197 cipher over byte arrays with an S-box derived from GF(2^8) inversion.
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid1, in_ready1, out_valid1, out_ready1;
  logic [127:0] pt1, key1, ct1, lk1;
  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [127:0] pt2, key2, ct2, lk2;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  always #5 clk = ~clk;

  aes128_encrypt_iter #(.RPC(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .plaintext(pt1), .key(key1), .out_valid(out_valid1), .out_ready(out_ready1),
    .ciphertext(ct1), .last_key(lk1)
  );

  aes128_encrypt_iter #(.RPC(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .plaintext(pt2), .key(key2), .out_valid(out_valid2), .out_ready(out_ready2),
    .ciphertext(ct2), .last_key(lk2)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] k,
                                               output logic [127:0] lk);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc;
    logic [31:0] tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
          s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    lk = {w[40], w[41], w[42], w[43]};
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Presents one block at a negedge and returns the negedge count until out_valid is seen.
  task automatic run_block(input int sel, input logic [127:0] pt, input logic [127:0] k,
                           output int lat);
    int n;
    n = 0;
    while (!(sel == 1 ? in_ready1 : in_ready2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sel == 1) begin pt1 = pt; key1 = k; in_valid1 = 1'b1; end
    else          begin pt2 = pt; key2 = k; in_valid2 = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (sel == 1) in_valid1 = 1'b0; else in_valid2 = 1'b0;
    end while (!(sel == 1 ? out_valid1 : out_valid2) && n < 100);
    lat = n;
  endtask

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LK_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int lat, cyc, idx, out_idx;
    logic acc;
    logic [127:0] ref_lk, hold_ct, hold_lk;
    logic [127:0] rp [4];
    logic [127:0] rk [4];
    logic [127:0] rc [4];
    int acc_cyc [4];

    rst = 1'b1;
    in_valid1 = 1'b0; out_ready1 = 1'b1; pt1 = '0; key1 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; pt2 = '0; key2 = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_in_ready", 256'(in_ready1), 256'(1'b1));
    check("reset_out_valid", 256'(out_valid1), 256'(1'b0));
    check("reset_ciphertext", 256'(ct1), 256'(0));
    check("reset_last_key", 256'(lk1), 256'(0));
    check("reset_in_ready_rpc2", 256'(in_ready2), 256'(1'b1));

    // FIPS-197 App.B
    run_block(1, PT_B, KEY_B, lat);
    check("appB_latency", 256'(lat), 256'(11));
    check("appB_ct", 256'(ct1), 256'(CT_B));
    check("appB_last_key", 256'(lk1), 256'(LK_B));
    check("appB_in_ready_done", 256'(in_ready1), 256'(1'b0));

    // FIPS-197 App.C.1 on both unroll factors
    run_block(1, PT_C, KEY_C, lat);
    check("appC_rpc1_latency", 256'(lat), 256'(11));
    check("appC_rpc1_ct", 256'(ct1), 256'(CT_C));
    run_block(2, PT_C, KEY_C, lat);
    check("appC_rpc2_latency", 256'(lat), 256'(6));
    check("appC_rpc2_ct", 256'(ct2), 256'(CT_C));
    void'(ref_encrypt(PT_C, KEY_C, ref_lk));
    check("appC_rpc2_last_key", 256'(lk2), 256'(ref_lk));

    // Backpressure: outputs frozen for 20 cycles
    @(negedge clk);
    out_ready1 = 1'b0;
    run_block(1, PT_B, KEY_B, lat);
    hold_ct = ct1;
    hold_lk = lk1;
    check("bp_ct", 256'(hold_ct), 256'(CT_B));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold", {ct1, lk1 ^ {126'h0, in_ready1, ~out_valid1}}, {CT_B, LK_B});
    end
    out_ready1 = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 256'(out_valid1), 256'(1'b0));
    check("bp_release_in_ready", 256'(in_ready1), 256'(1'b1));

    // Busy input: new data pulsed mid-ROUND must be ignored
    pt1 = PT_B; key1 = KEY_B; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    pt1 = rand128(); key1 = rand128(); in_valid1 = 1'b1;
    repeat (2) @(negedge clk);
    in_valid1 = 1'b0;
    lat = 6;
    while (!out_valid1 && lat < 100) begin @(negedge clk); lat++; end
    check("busy_latency", 256'(lat), 256'(11));
    check("busy_ct", 256'(ct1), 256'(CT_B));
    repeat (4) @(negedge clk);
    check("busy_no_extra_block", {255'(out_valid1), in_ready1}, {255'(0), 1'b1});

    // Reset at cycle 5 of ROUND
    pt1 = PT_B; key1 = KEY_B; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 256'(out_valid1), 256'(1'b0));
    check("rst_in_ready", 256'(in_ready1), 256'(1'b1));
    check("rst_ciphertext", 256'(ct1), 256'(0));
    acc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      acc = acc | out_valid1;
    end
    check("rst_no_late_output", 256'(acc), 256'(1'b0));
    run_block(1, PT_C, KEY_C, lat);
    check("rst_then_appC_ct", 256'(ct1), 256'(CT_C));
    @(negedge clk);

    // Back-to-back random blocks with in_valid held high
    for (int i = 0; i < 4; i++) begin
      rp[i] = rand128();
      rk[i] = rand128();
      rc[i] = ref_encrypt(rp[i], rk[i], ref_lk);
    end
    idx = 0; out_idx = 0; cyc = 0;
    pt1 = rp[0]; key1 = rk[0]; in_valid1 = 1'b1;
    while (out_idx < 4 && cyc < 300) begin
      if (out_valid1) begin
        check($sformatf("b2b_ct%0d", out_idx), 256'(ct1), 256'(rc[out_idx]));
        out_idx++;
      end
      acc = in_ready1 && in_valid1;
      if (acc) acc_cyc[idx] = cyc;
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) begin pt1 = rp[idx]; key1 = rk[idx]; end
        else in_valid1 = 1'b0;
      end
    end
    in_valid1 = 1'b0;
    check("b2b_outputs", 256'(out_idx), 256'(4));
    for (int i = 0; i < 3; i++)
      check($sformatf("b2b_spacing%0d", i), 256'(acc_cyc[i+1] - acc_cyc[i]), 256'(12));

    // Random block through the two-rounds-per-clock core
    rp[0] = rand128();
    rk[0] = rand128();
    rc[0] = ref_encrypt(rp[0], rk[0], ref_lk);
    run_block(2, rp[0], rk[0], lat);
    check("rand_rpc2_latency", 256'(lat), 256'(6));
    check("rand_rpc2_ct", 256'(ct2), 256'(rc[0]));
    check("rand_rpc2_last_key", 256'(lk2), 256'(ref_lk));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
